// File: rtl/serial_mag_comp.sv
// serial_mag_comp: MSB-first bit-serial magnitude comparator.
// Operands in and g/l out via valid/ready; scan stops at first differing bit.
module serial_mag_comp #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         g,
  output logic         l,
  output logic         busy
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  xr_q;
  logic [N-1:0]  yr_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          g_q;
  logic          l_q;
  logic          in_ready_q;
  logic          busy_q;
  logic          out_valid_q;
  logic          xb;
  logic          yb;

  // Current bit pair under examination and next index.
  assign xb    = xr_q[idx_q];
  assign yb    = yr_q[idx_q];
  assign idx_d = idx_q - 1'b1;

  // Control FSM; handshake flags are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xr_q        <= '0;
      yr_q        <= '0;
      idx_q       <= '0;
      g_q         <= 1'b0;
      l_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            xr_q       <= x;
            yr_q       <= y;
            idx_q      <= IW'(N - 1);
            state_q    <= SCAN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          if (xb != yb) begin
            g_q         <= xb;
            l_q         <= yb;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (idx_q == '0) begin
            g_q         <= 1'b0;
            l_q         <= 1'b0;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign g         = g_q;
  assign l         = l_q;

endmodule
